// File: rtl/prm_chk_pkg.sv
// Shared types for the PRM obstacle-check bank and its sweep sequencer.
package prm_chk_pkg;

  localparam int CODE_W      = 15;
  localparam int NUM_CHK_DEF = 16;

  // bit 0 = input A ... bit 14 = input O
  typedef logic [CODE_W-1:0] edge_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/prm_edge_sweep_ctrl_if.sv
// Request/result handshake between the roadmap builder (master) and the
// edge sweep controller (slave).
interface prm_edge_sweep_ctrl_if
  import prm_chk_pkg::*;
#(
  parameter int NUM_CHK = NUM_CHK_DEF
);

  localparam int SEL_W = $clog2(NUM_CHK);

  logic               req_valid;
  logic               req_ready;
  edge_code_t         req_code;
  logic               res_valid;
  logic               res_ready;
  logic [NUM_CHK-1:0] res_vec;
  logic [SEL_W:0]     res_hits;

  modport master (
    output req_valid, req_code, res_ready,
    input  req_ready, res_valid, res_vec, res_hits
  );

  modport slave (
    input  req_valid, req_code, res_ready,
    output req_ready, res_valid, res_vec, res_hits
  );

endinterface

// File: rtl/prm_edge_sweep_ctrl.sv
// Walks one edge code across the shared obstacle-check bank, one cell per
// cycle, and returns the collision vector and hit count.
// Optional macro PRM_SWEEP_EARLY_EXIT_EN: stop the sweep at the first hit.
module prm_edge_sweep_ctrl
  import prm_chk_pkg::*;
#(
  parameter int NUM_CHK = NUM_CHK_DEF,
  parameter int SEL_W   = $clog2(NUM_CHK)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prm_edge_sweep_ctrl_if.slave   bus,
  input  logic                   abort,
  output logic [SEL_W-1:0]       chk_sel,
  output edge_code_t             chk_code,
  input  logic                   chk_mask,
  output logic                   busy
);

  sweep_state_e       state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg;
  edge_code_t         code_reg;
  logic [NUM_CHK-1:0] vec_reg;
  logic [SEL_W:0]     hits_reg;

  logic               accept;
  logic               sample_en;
  logic               sel_at_end;
  logic               last_step;
  logic [NUM_CHK-1:0] sel_hit;

  assign sel_at_end = (sel_reg == SEL_W'(NUM_CHK - 1));

`ifdef PRM_SWEEP_EARLY_EXIT_EN
  assign last_step = sel_at_end | chk_mask;
`else
  assign last_step = sel_at_end;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHK; gi++) begin : g_sel_hit
      assign sel_hit[gi] = (sel_reg == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // abort outranks both the final sweep step and the consumer's res_ready
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.req_valid) state_next = SWEEP;
      SWEEP:   if (abort) state_next = IDLE;
               else if (last_step) state_next = DONE;
      DONE:    if (abort || bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_reg == IDLE);
    bus.res_valid = (state_reg == DONE);
    busy          = (state_reg != IDLE);
    accept        = (state_reg == IDLE) && bus.req_valid;
    sample_en     = (state_reg == SWEEP) && !abort;
  end

  // Result registers survive abort and DONE->IDLE; only a new accept clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg  <= '0;
      code_reg <= '0;
      vec_reg  <= '0;
      hits_reg <= '0;
    end else if (accept) begin
      sel_reg  <= '0;
      code_reg <= bus.req_code;
      vec_reg  <= '0;
      hits_reg <= '0;
    end else if (sample_en) begin
      vec_reg  <= (vec_reg & ~sel_hit) | (sel_hit & {NUM_CHK{chk_mask}});
      hits_reg <= hits_reg + {{SEL_W{1'b0}}, chk_mask};
      if (!last_step) begin
        sel_reg <= sel_reg + 1'b1;
      end
    end
  end

  assign chk_sel      = sel_reg;
  assign chk_code     = code_reg;
  assign bus.res_vec  = vec_reg;
  assign bus.res_hits = hits_reg;

endmodule

// File: doc/prm_edge_sweep_ctrl.md
Name: prm_edge_sweep_ctrl

Overview:
- Sequencer for the bank of combinational PRM obstacle-check cells (one cell per obstacle, each taking a 15-bit code and returning edge_mask).
- Accepts one 15-bit joint-space edge code per request and presents it to the shared check bank through a select index, one cell per cycle.
- Collects each cell's edge_mask into a NUM_CHK-bit collision vector plus a hit count, then returns the result over a valid/ready handshake to the roadmap builder.

Parameters:
- NUM_CHK, 16, number of check cells in the bank (must be >= 2).
- CODE_W, 15, width of the edge code (inputs A..O; bit 0 = A, bit 14 = O).
- SEL_W, $clog2(NUM_CHK), width of the cell select index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_code  in  CODE_W  edge code to check.
- abort  in  1  abandon the current sweep.
- chk_sel  out  SEL_W  index of the cell currently selected in the bank.
- chk_code  out  CODE_W  code driven to the bank (registered).
- chk_mask  in  1  edge_mask of the selected cell (combinational return from the bank mux).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_vec  out  NUM_CHK  bit i = edge_mask of cell i.
- res_hits  out  SEL_W+1  popcount of res_vec.
- busy  out  1  high in SWEEP or DONE.

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - chk_sel, chk_code, res_vec, res_hits = 0.
  - res_valid = 0, req_ready = 1, busy = 0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch req_code into chk_code, set chk_sel = 0, clear res_vec and res_hits, go to SWEEP.
- SWEEP:
  - Each cycle, sample chk_mask into res_vec[chk_sel].
  - Add chk_mask to res_hits.
  - chk_sel increments by 1.
  - When chk_sel == NUM_CHK-1, sample the last bit, hold chk_sel, go to DONE.
  - Sweep length is exactly NUM_CHK cycles. res_valid rises on cycle NUM_CHK+1 after the accept edge.
- DONE:
  - res_valid = 1. res_vec and res_hits are stable.
  - On res_ready, go to IDLE next cycle; res_valid drops the same cycle.
  - res_vec and res_hits keep their values until the next accept.
- abort:
  - Sampled in SWEEP and DONE. Next state is IDLE.
  - No res_valid is produced, and res_vec/res_hits are not cleared until the next accept.
  - abort has priority over the last-step transition and over res_ready.
  - abort is ignored in IDLE.
- req_valid outside IDLE is ignored (req_ready = 0); no queueing.
- chk_code is constant for the whole sweep; the bank is combinational, so chk_mask is valid in the same cycle as chk_sel.
- res_hits saturates naturally: its maximum is NUM_CHK, which fits SEL_W+1.
- An asynchronous reset mid-sweep discards everything; no partial result is emitted.

Optional Feature:
- Macro: PRM_SWEEP_EARLY_EXIT_EN.
- Defined:
  - In SWEEP, the first sampled chk_mask = 1 ends the sweep: state goes to DONE in that cycle.
  - Remaining res_vec bits stay 0 and res_hits = 1.
  - Latency is (index of first hit) + 2 cycles.
  - A sweep with no hits behaves as full length.
- Not defined: the full sweep always runs, as specified above.

Decomposition:
- Shared package prm_chk_pkg holds:
  - CODE_W.
  - The state enum (IDLE/SWEEP/DONE).
  - The edge-code typedef (packed [CODE_W-1:0]).
  - NUM_CHK default.
- One natural sub-module, prm_chk_bank_mux: instantiates the NUM_CHK check cells, all fed by chk_code, and selects chk_mask by chk_sel.
  - It lives outside this controller and is instantiated by the integration top.
  - The bench uses a behavioural model of it.

Test Plan:
- Reset then idle (NUM_CHK=16) -> req_ready=1, res_valid=0, res_vec=0, chk_sel=0.
- Request code 15'h1234, model returns mask=1 for cells 3 and 10 -> res_valid 17 cycles after accept, res_vec=16'h0408, res_hits=2, chk_code=15'h1234 throughout.
- Hold res_ready=0 for 5 cycles in DONE, offer a second request meanwhile -> result stable, req_ready=0, second request not taken; res_ready=1 -> IDLE next cycle, then second request accepted.
- abort asserted on sweep cycle 7 (and again on the last cycle in a second run) -> IDLE next cycle, res_valid never rises.
- rst_n pulsed low mid-sweep at chk_sel=5 -> all outputs return to reset values immediately, no result after release.
- Early exit with PRM_SWEEP_EARLY_EXIT_EN defined, first hit at cell 4 -> res_valid 6 cycles after accept, res_vec=16'h0010, res_hits=1. With the macro undefined -> full 17-cycle latency.
